// File: rtl/sensor_image_window_pkg.sv
// Shared types and helpers for the sensor crop window: FSM encoding, stats counter
// width and the offset clamp used when the window position is latched.
package sensor_image_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FRAME = 2'd1,
    S_BLANK = 2'd2
  } win_state_e;

  localparam int FRAME_CNT_W = 16;

  // Keeps the window inside the source: offsets beyond lim snap to lim.
  function automatic int unsigned clamp_off(input int unsigned off, input int unsigned lim);
    if (off > lim) begin
      return lim;
    end else begin
      return off;
    end
  endfunction

endpackage

// File: rtl/sensor_image_window_if.sv
// Video stream bundle (frame sync, line valid, pixel) shared by the capture side
// and the frame-writer side of the crop window.
interface sensor_image_window_if #(
  parameter int DATA_W = 8
) ();
  logic              vsync;
  logic              href;
  logic [DATA_W-1:0] data;

  modport master (output vsync, href, data);
  modport slave  (input  vsync, href, data);
endinterface

// File: rtl/sensor_image_window_sync_edge_detect.sv
// One-cycle rise/fall pulses of a level, taken against its registered previous value.
// The history register always follows the input, so a level already present at reset release is not an edge.
module sync_edge_detect (
  input  logic clk,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Previous-cycle copy of the monitored level.
  always_ff @(posedge clk) begin
    sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/sensor_image_window.sv
// Runtime-positioned crop window on the sensor stream, 1-cycle registered latency.
// Macro SENSOR_WINDOW_STATS_EN adds frame_cnt / short_err; otherwise both are tied 0.
module sensor_image_window
  import sensor_image_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SRC_H     = 1280,
  parameter int SRC_V     = 720,
  parameter int TGT_H     = 1024,
  parameter int TGT_V     = 600,
  parameter int VSYNC_POL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(SRC_H)-1:0] x_off,
  input  logic [$clog2(SRC_V)-1:0] y_off,
  sensor_image_window_if.slave     vid_in,
  sensor_image_window_if.master    vid_out,
  output logic [FRAME_CNT_W-1:0]   frame_cnt,
  output logic                     short_err
);

  localparam int XO_W   = $clog2(SRC_H);
  localparam int YO_W   = $clog2(SRC_V);
  localparam int PIX_W  = $clog2(SRC_H + 1);
  localparam int LIN_W  = $clog2(SRC_V + 1);
  localparam int XO_MAX = SRC_H - TGT_H;
  localparam int YO_MAX = SRC_V - TGT_V;
  localparam logic VS_ACT  = (VSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_IDLE = (VSYNC_POL != 0) ? 1'b0 : 1'b1;

  win_state_e        state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LIN_W-1:0]  line_cnt_q, line_cnt_d;
  logic [XO_W-1:0]   xo_q, xo_d;
  logic [YO_W-1:0]   yo_q, yo_d;
  logic              out_vsync_q, out_vsync_d;
  logic              out_href_q, out_href_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic vs_act_s, fs_s, fe_s, le_s, href_rise_unused_s;
  logic pix_in_s, line_in_s;

  assign vs_act_s = (vid_in.vsync == VS_ACT);

  sync_edge_detect u_vs_edge (
    .clk    (clk),
    .sig_i  (vs_act_s),
    .rise_o (fs_s),
    .fall_o (fe_s)
  );

  sync_edge_detect u_href_edge (
    .clk    (clk),
    .sig_i  (vid_in.href),
    .rise_o (href_rise_unused_s),
    .fall_o (le_s)
  );

  assign pix_in_s  = (32'(pix_cnt_q) >= 32'(xo_q)) &&
                     (32'(pix_cnt_q) < (32'(xo_q) + 32'(TGT_H)));
  assign line_in_s = (32'(line_cnt_q) >= 32'(yo_q)) &&
                     (32'(line_cnt_q) < (32'(yo_q) + 32'(TGT_V)));

  // Frame state: output is only ungated between a seen frame start and its end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (fs_s) state_d = S_FRAME; else state_d = S_WAIT;
      S_FRAME: if (fe_s) state_d = S_BLANK; else state_d = S_FRAME;
      S_BLANK: if (fs_s) state_d = S_FRAME; else state_d = S_BLANK;
      default: state_d = S_WAIT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Position counters and per-frame offset latch; frame start outranks line end.
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    xo_d       = xo_q;
    yo_d       = yo_q;
    if (fs_s) begin
      pix_cnt_d  = {PIX_W{1'b0}};
      line_cnt_d = {LIN_W{1'b0}};
      xo_d       = XO_W'(clamp_off(32'(x_off), 32'(XO_MAX)));
      yo_d       = YO_W'(clamp_off(32'(y_off), 32'(YO_MAX)));
    end else begin
      if (le_s) begin
        pix_cnt_d = {PIX_W{1'b0}};
      end else if (vid_in.href && (pix_cnt_q < PIX_W'(SRC_H))) begin
        pix_cnt_d = pix_cnt_q + {{(PIX_W-1){1'b0}}, 1'b1};
      end else begin
        pix_cnt_d = pix_cnt_q;
      end
      if (le_s && (line_cnt_q < LIN_W'(SRC_V))) begin
        line_cnt_d = line_cnt_q + {{(LIN_W-1){1'b0}}, 1'b1};
      end else begin
        line_cnt_d = line_cnt_q;
      end
    end
  end

  // Output stage; vsync follows the next state so it rises together with the frame it opens.
  always_comb begin
    out_href_d  = (state_q == S_FRAME) && vid_in.href && pix_in_s && line_in_s;
    out_data_d  = {DATA_W{1'b0}};
    out_vsync_d = VS_IDLE;
    if (out_href_d) begin
      out_data_d = vid_in.data;
    end else begin
      out_data_d = {DATA_W{1'b0}};
    end
    if (state_d == S_WAIT) begin
      out_vsync_d = VS_IDLE;
    end else begin
      out_vsync_d = vid_in.vsync;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt_q   <= {PIX_W{1'b0}};
      line_cnt_q  <= {LIN_W{1'b0}};
      xo_q        <= {XO_W{1'b0}};
      yo_q        <= {YO_W{1'b0}};
      out_vsync_q <= VS_IDLE;
      out_href_q  <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      xo_q        <= xo_d;
      yo_q        <= yo_d;
      out_vsync_q <= out_vsync_d;
      out_href_q  <= out_href_d;
      out_data_q  <= out_data_d;
    end
  end

  assign vid_out.vsync = out_vsync_q;
  assign vid_out.href  = out_href_q;
  assign vid_out.data  = out_data_q;

`ifdef SENSOR_WINDOW_STATS_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   short_err_q, short_err_d;
  logic                   short_line_q, short_line_d;
  logic                   frame_end_s, line_short_s;
  logic [31:0]            lines_seen_s;

  assign frame_end_s  = fe_s && (state_q == S_FRAME);
  assign line_short_s = le_s && (32'(pix_cnt_q) < (32'(xo_q) + 32'(TGT_H)));
  // A line ending in the same cycle as the frame still counts toward the frame.
  assign lines_seen_s = 32'(line_cnt_q) + 32'(le_s);

  // Frame counter and short-frame detection.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    short_line_d = short_line_q;
    short_err_d  = 1'b0;
    if (fs_s) begin
      short_line_d = 1'b0;
    end else if (line_short_s) begin
      short_line_d = 1'b1;
    end else begin
      short_line_d = short_line_q;
    end
    if (frame_end_s) begin
      frame_cnt_d = frame_cnt_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      short_err_d = (lines_seen_s < (32'(yo_q) + 32'(TGT_V))) || short_line_q || line_short_s;
    end else begin
      frame_cnt_d = frame_cnt_q;
      short_err_d = 1'b0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q  <= {FRAME_CNT_W{1'b0}};
      short_err_q  <= 1'b0;
      short_line_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      short_err_q  <= short_err_d;
      short_line_q <= short_line_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign short_err = short_err_q;
`else
  assign frame_cnt = {FRAME_CNT_W{1'b0}};
  assign short_err = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_image_window.sv
// Bench for sensor_image_window: table of frames (offsets, resets, mid-frame changes)
// with a pixel scoreboard, plus per-frame count/first/last/stat checks.
module tb_sensor_image_window;

  localparam int DW = 8;
  localparam int SH = 16;
  localparam int SV = 8;
  localparam int TH = 8;
  localparam int TV = 4;
`ifdef SENSOR_WINDOW_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  x_off = 4'd0;
  logic [2:0]  y_off = 3'd0;
  logic [15:0] frame_cnt;
  logic        short_err;

  sensor_image_window_if #(.DATA_W(DW)) vin ();
  sensor_image_window_if #(.DATA_W(DW)) vout ();

  sensor_image_window #(
    .DATA_W(DW), .SRC_H(SH), .SRC_V(SV), .TGT_H(TH), .TGT_V(TV), .VSYNC_POL(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_off     (x_off),
    .y_off     (y_off),
    .vid_in    (vin),
    .vid_out   (vout),
    .frame_cnt (frame_cnt),
    .short_err (short_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x_off; int y_off; int nlines;
    int rl; int rp; int hl; int hp;
    int chg_line; int chg_x;
    int exp_cnt; int exp_first; int exp_last; int exp_fc; int exp_se;
  } vec_t;

  vec_t       vecs[8];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         se_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pops on every emitted pixel; idle cycles must carry zero data.
  always @(negedge clk) begin
    if (vout.href === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pixel: got %0h, no pixel expected", vout.data);
      end else begin
        check("pixel", int'(vout.data), int'(exp_q.pop_front()));
      end
      got_q.push_back(vout.data);
    end else begin
      check("idle_data", int'(vout.data), 0);
    end
    if (short_err === 1'b1) se_cnt++;
  end

  task automatic run_frame(input int idx, input vec_t v);
    int xo, yo, base_se;
    bit valid;
    xo = (v.x_off > SH - TH) ? SH - TH : v.x_off;
    yo = (v.y_off > SV - TV) ? SV - TV : v.y_off;
    base_se = se_cnt;
    got_q.delete();
    @(negedge clk);
    x_off = 4'(v.x_off);
    y_off = 3'(v.y_off);
    vin.vsync = 1'b1;
    vin.href = 1'b0;
    vin.data = 8'hEE;
    valid = rst_n;
    repeat (2) @(negedge clk);
    for (int l = 0; l < v.nlines; l++) begin
      for (int p = 0; p < SH; p++) begin
        @(negedge clk);
        if (l == v.rl && p == v.rp) begin
          rst_n = 1'b0;
          valid = 1'b0;
        end
        if (l == v.hl && p == v.hp) rst_n = 1'b1;
        if (l == v.rl && p == v.rp + 1) begin
          check("rst_pulse_href", int'(vout.href), 0);
          check("rst_pulse_data", int'(vout.data), 0);
          check("rst_pulse_vsync", int'(vout.vsync), 0);
        end
        if (l == 0 && p == 0) check("frame_vsync", int'(vout.vsync), valid ? 1 : 0);
        if (l == v.chg_line && p == 0) x_off = 4'(v.chg_x);
        vin.href = 1'b1;
        vin.data = {l[3:0], p[3:0]};
        if (valid && rst_n && p >= xo && p < xo + TH && l >= yo && l < yo + TV)
          exp_q.push_back({l[3:0], p[3:0]});
      end
      repeat (2) begin
        @(negedge clk);
        vin.href = 1'b0;
        vin.data = 8'hEE;
      end
    end
    @(negedge clk);
    vin.vsync = 1'b0;
    repeat (5) @(negedge clk);
    check($sformatf("f%0d_count", idx), got_q.size(), v.exp_cnt);
    if (v.exp_cnt > 0 && got_q.size() > 0) begin
      check($sformatf("f%0d_first", idx), int'(got_q[0]), v.exp_first);
      check($sformatf("f%0d_last", idx), int'(got_q[got_q.size() - 1]), v.exp_last);
    end
    check($sformatf("f%0d_missing", idx), exp_q.size(), 0);
    exp_q.delete();
    check($sformatf("f%0d_frame_cnt", idx), int'(frame_cnt), STATS ? v.exp_fc : 0);
    check($sformatf("f%0d_short_err", idx), se_cnt - base_se, STATS ? v.exp_se : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Entry 0 starts under reset and releases mid-frame: nothing may be emitted.
    vecs[0] = '{4, 2, 8, -1, -1,  1, 0, -1, 0,  0, 8'h00, 8'h00, 0, 0};
    vecs[1] = '{4, 2, 8, -1, -1, -1, -1, -1, 0, 32, 8'h24, 8'h5B, 1, 0};
    vecs[2] = '{0, 0, 8, -1, -1, -1, -1, -1, 0, 32, 8'h00, 8'h37, 2, 0};
    vecs[3] = '{4, 2, 8,  3,  6,  3,  7, -1, 0, 10, 8'h24, 8'h35, 0, 0};
    vecs[4] = '{12, 7, 8, -1, -1, -1, -1, -1, 0, 32, 8'h48, 8'h7F, 1, 0};
    vecs[5] = '{0, 2, 8, -1, -1, -1, -1,  3, 4, 32, 8'h20, 8'h57, 2, 0};
    vecs[6] = '{4, 2, 8, -1, -1, -1, -1, -1, 0, 32, 8'h24, 8'h5B, 3, 0};
    vecs[7] = '{4, 2, 4, -1, -1, -1, -1, -1, 0, 16, 8'h24, 8'h3B, 4, 1};

    vin.vsync = 1'b0;
    vin.href  = 1'b0;
    vin.data  = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_href", int'(vout.href), 0);
    check("rst_data", int'(vout.data), 0);
    check("rst_vsync", int'(vout.vsync), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_short_err", int'(short_err), 0);

    for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
